// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT sequencer state type, default sizing and twiddle width
package fft_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} fft_seq_state_t;
    localparam int FFT_N_LOG2 = 8;
    localparam int FFT_READ_LAT = 1;
    localparam int FFT_TW_W = FFT_N_LOG2 - 1;
    function automatic int tw_width(input int n_log2);
        return n_log2 - 1;
    endfunction
endpackage

// File: rtl/fft_sequencer_addr_gen.sv
// fft_addr_gen: butterfly read addresses and twiddle index from stage s and butterfly k
// ports: s, k in; addr_a, addr_b, tw out (combinational)
module fft_addr_gen import fft_pkg::*; #(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int SW = $clog2(N_LOG2)
) (
    input  logic [SW-1:0]               s,
    input  logic [N_LOG2-2:0]           k,
    output logic [N_LOG2-1:0]           addr_a,
    output logic [N_LOG2-1:0]           addr_b,
    output logic [tw_width(N_LOG2)-1:0] tw
);
    logic [N_LOG2-1:0] half, p, j;
    always_comb begin
        half = N_LOG2'(1) << s;
        p = {1'b0, k} & (half - N_LOG2'(1));
        j = {1'b0, k} >> s;
        addr_a = ((j << s) << 1) | p;
        addr_b = addr_a + half;
        tw = tw_width(N_LOG2)'(p << (SW'(N_LOG2 - 1) - s));
    end
endmodule

// File: rtl/fft_sequencer.sv
// fft_sequencer: in-place radix-2 DIT FFT read/twiddle/write-back address sequencer
// ports: clk, rst, start, [stall with FFT_SEQ_STALL_EN] in; busy, done, rd_en, rd_addr_a/b,
//        tw_addr, wr_en, wr_addr_a/b, stage out; optional stall gated by FFT_SEQ_STALL_EN
module fft_sequencer import fft_pkg::*; #(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int READ_LAT = FFT_READ_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef FFT_SEQ_STALL_EN
    input  logic                        stall,
`endif
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [N_LOG2-1:0]           rd_addr_a,
    output logic [N_LOG2-1:0]           rd_addr_b,
    output logic [tw_width(N_LOG2)-1:0] tw_addr,
    output logic                        wr_en,
    output logic [N_LOG2-1:0]           wr_addr_a,
    output logic [N_LOG2-1:0]           wr_addr_b,
    output logic [$clog2(N_LOG2)-1:0]   stage
);
    localparam int SW = $clog2(N_LOG2);
    localparam int TW = tw_width(N_LOG2);
    localparam int PW = 2 * N_LOG2 + 1;
    fft_seq_state_t state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [N_LOG2-2:0] k_q, k_d;
    logic [2:0] cnt_q, cnt_d;
    logic busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, wr_v;
    logic [N_LOG2-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d, gen_a, gen_b;
    logic [TW-1:0] tw_q, tw_d, gen_tw;
    logic [READ_LAT-1:0][PW-1:0] pipe_q, pipe_d;
    logic hold;

    // a stalled cycle freezes everything and re-presents the same op once stall drops
`ifdef FFT_SEQ_STALL_EN
    assign hold = stall && (state_q == RUN || state_q == FLUSH);
`else
    assign hold = 1'b0;
`endif

    // addresses are generated from the next counters so the outputs leave a flop
    fft_addr_gen #(.N_LOG2(N_LOG2), .SW(SW)) u_gen (
        .s(s_d), .k(k_d), .addr_a(gen_a), .addr_b(gen_b), .tw(gen_tw)
    );

    always_comb begin
        state_d = state_q;
        s_d = s_q;
        k_d = k_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                s_d = '0;
                k_d = '0;
            end
            RUN: if (&k_q) begin
                state_d = FLUSH;
                cnt_d = '0;
            end else k_d = k_q + 1'b1;
            FLUSH: if (cnt_q != 3'(READ_LAT - 1)) cnt_d = cnt_q + 1'b1;
            else if (s_q == SW'(N_LOG2 - 1)) state_d = DONE;
            else begin
                state_d = RUN;
                s_d = s_q + 1'b1;
                k_d = '0;
            end
            DONE: begin
                state_d = IDLE;
                s_d = '0;
                k_d = '0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        rd_en_d = state_d == RUN;
        rd_a_d = rd_en_d ? gen_a : '0;
        rd_b_d = rd_en_d ? gen_b : '0;
        tw_d = rd_en_d ? gen_tw : '0;
    end

    // write-back delay line: entry 0 holds the op issued last cycle
    if (READ_LAT == 1) begin : g_pipe1
        assign pipe_d = {rd_en_q, rd_a_q, rd_b_q};
    end else begin : g_pipen
        assign pipe_d = {pipe_q[READ_LAT-2:0], {rd_en_q, rd_a_q, rd_b_q}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q <= '0;
            k_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q <= '0;
            rd_b_q <= '0;
            tw_q <= '0;
            pipe_q <= '0;
        end else if (!hold) begin
            state_q <= state_d;
            s_q <= s_d;
            k_q <= k_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rd_en_q <= rd_en_d;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            tw_q <= tw_d;
            pipe_q <= pipe_d;
        end
    end

    assign {wr_v, wr_addr_a, wr_addr_b} = pipe_q[READ_LAT-1];
    assign wr_en = wr_v && !hold;
    assign rd_en = rd_en_q && !hold;
    assign busy = busy_q;
    assign done = done_q;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_addr = tw_q;
    assign stage = s_q;
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: randomized self-checking bench against a butterfly-list reference model
module tb_fft_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st3 = 1'b0, st4 = 1'b0;
`ifdef FFT_SEQ_STALL_EN
    logic stl3 = 1'b0, stl4 = 1'b0;
`endif
    logic bz3, dn3, re3, we3, bz4, dn4, re4, we4;
    logic [2:0] ra3, rb3, wa3, wb3;
    logic [1:0] tw3, sg3, sg4;
    logic [3:0] ra4, rb4, wa4, wb4;
    logic [2:0] tw4;
    logic o_re, o_we, o_bz, o_dn;
    logic [31:0] o_ra, o_rb, o_tw, o_wa, o_wb, o_sg;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fft_sequencer #(.N_LOG2(3), .READ_LAT(1)) u3 (
        .clk(clk), .rst(rst),
`ifdef FFT_SEQ_STALL_EN
        .stall(stl3),
`endif
        .start(st3), .busy(bz3), .done(dn3), .rd_en(re3), .rd_addr_a(ra3), .rd_addr_b(rb3),
        .tw_addr(tw3), .wr_en(we3), .wr_addr_a(wa3), .wr_addr_b(wb3), .stage(sg3)
    );

    fft_sequencer #(.N_LOG2(4), .READ_LAT(3)) u4 (
        .clk(clk), .rst(rst),
`ifdef FFT_SEQ_STALL_EN
        .stall(stl4),
`endif
        .start(st4), .busy(bz4), .done(dn4), .rd_en(re4), .rd_addr_a(ra4), .rd_addr_b(rb4),
        .tw_addr(tw4), .wr_en(we4), .wr_addr_a(wa4), .wr_addr_b(wb4), .stage(sg4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic smp(input int d);
        if (d == 0) begin
            o_re = re3; o_we = we3; o_bz = bz3; o_dn = dn3;
            o_ra = 32'(ra3); o_rb = 32'(rb3); o_tw = 32'(tw3);
            o_wa = 32'(wa3); o_wb = 32'(wb3); o_sg = 32'(sg3);
        end else begin
            o_re = re4; o_we = we4; o_bz = bz4; o_dn = dn4;
            o_ra = 32'(ra4); o_rb = 32'(rb4); o_tw = 32'(tw4);
            o_wa = 32'(wa4); o_wb = 32'(wb4); o_sg = 32'(sg4);
        end
    endtask

    task automatic drive(input int d, input logic s);
        if (d == 0) st3 = s;
        else st4 = s;
    endtask

    task automatic chk_zero(input int d, input string tag);
        smp(d);
        chk({tag, "_ctl"}, 32'({o_re, o_we, o_bz, o_dn}), 0);
        chk({tag, "_addr"}, o_ra | o_rb | o_tw | o_wa | o_wb | o_sg, 0);
    endtask

    task automatic run(input int d, input int mid, input int stall_at);
        int n = d ? 4 : 3;
        int rl = d ? 3 : 1;
        int nn = 1 << n;
        int base = n * (nn / 2 + rl);
        int sl = stall_at >= 0 ? 5 : 0;
        int ea[$], eb[$], et[$], es[$], rcyc[$];
        int ri = 0, wi = 0, bcnt = 0, dcnt = 0, dcyc = -1;
        int fr[4], lw[4];
        for (int s = 0; s < 4; s++) begin
            fr[s] = -1;
            lw[s] = -1;
        end
        for (int s = 0; s < n; s++)
            for (int a = 0; a < nn; a++)
                if (((a >> s) & 1) == 0) begin
                    ea.push_back(a);
                    eb.push_back(a + (1 << s));
                    et.push_back((a % (1 << s)) * ((nn / 2) / (1 << s)));
                    es.push_back(s);
                end
        @(negedge clk);
        drive(d, 1'b1);
        for (int c = 0; c < 300 && dcyc < 0; c++) begin
            @(negedge clk);
            drive(d, c == mid);
`ifdef FFT_SEQ_STALL_EN
            if (d == 0) stl3 = stall_at >= 0 && c >= stall_at && c < stall_at + 5;
            else stl4 = stall_at >= 0 && c >= stall_at && c < stall_at + 5;
`endif
            #1;
            smp(d);
            if (c == 0) begin
                chk("first_rd", 32'(o_re), 1);
                chk("busy_on", 32'(o_bz), 1);
            end
            if (stall_at < 0 && c == rl) chk("first_wr", 32'(o_we), 1);
            if (o_bz && !o_dn) bcnt++;
            if (o_dn) begin
                dcnt++;
                dcyc = c;
                chk("done_busy", 32'(o_bz), 1);
            end
            if (o_re) begin
                if (ri < ea.size()) begin
                    chk("rd_a", o_ra, ea[ri]);
                    chk("rd_b", o_rb, eb[ri]);
                    chk("tw", o_tw, et[ri]);
                    chk("stage", o_sg, es[ri]);
                    if (fr[es[ri]] < 0) fr[es[ri]] = c;
                end
                rcyc.push_back(c);
                ri++;
            end
            if (o_we) begin
                if (wi < ea.size()) begin
                    chk("wr_a", o_wa, ea[wi]);
                    chk("wr_b", o_wb, eb[wi]);
                    if (stall_at < 0) chk("wr_lat", wi < rcyc.size() ? c - rcyc[wi] : -1, rl);
                    lw[es[wi]] = c;
                end
                wi++;
            end
        end
`ifdef FFT_SEQ_STALL_EN
        stl3 = 1'b0;
        stl4 = 1'b0;
`endif
        @(negedge clk);
        drive(d, 1'b0);
        #1;
        smp(d);
        chk("busy_off", 32'(o_bz), 0);
        chk("done_pulse", 32'(o_dn), 0);
        chk("done_cnt", dcnt, 1);
        chk("done_cyc", dcyc, base + sl);
        chk("busy_len", bcnt, base + sl);
        chk("n_rd", ri, n * nn / 2);
        chk("n_wr", wi, n * nn / 2);
        for (int s = 0; s + 1 < n; s++) chk("order", 32'(fr[s + 1] > lw[s]), 1);
    endtask

    initial begin
        int found;
        repeat (3) @(negedge clk);
        #1;
        chk_zero(0, "rst3");
        chk_zero(1, "rst4");
        rst = 1'b0;
        run(0, -1, -1);
        run(1, -1, -1);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(0, $urandom_range(1, 13), -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(1, $urandom_range(1, 40), -1);
        end
        @(negedge clk);
        drive(0, 1'b1);
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            @(negedge clk);
            drive(0, 1'b0);
            #1;
            smp(0);
            if (o_sg == 1 && o_re) found = 1;
        end
        chk("reach_stage1", found, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_zero(0, "rst_mid");
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            smp(0);
            chk("quiet_after_rst", 32'({o_we, o_re, o_bz}), 0);
        end
        run(0, -1, -1);
`ifdef FFT_SEQ_STALL_EN
        run(0, -1, $urandom_range(1, 2));
        run(1, -1, $urandom_range(1, 4));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Control sequencer for the in-place radix-2 decimation-in-time FFT engine built around the combinational butterfly datapath. On each `start` it walks every stage and butterfly of an N-point transform. Each cycle it issues one read-address pair to the dual-port sample RAM and one index to the twiddle ROM. After the RAM read latency it issues the matching write-back of the butterfly `sum` and `diff` results. It sits between the frame-capture logic, which loads bit-reversed samples and pulses `start`, and the magnitude/visualizer stage, which waits for `done`.

## Interface
- `N_LOG2`, 8, log2 of transform size N (valid 2..12)
- `READ_LAT`, 1, cycles from RAM address to valid read data (valid 1..4)
- `clk` input 1: clock, all logic rising-edge
- `rst` input 1: synchronous active-high reset
- `start` input 1: begin transform; sampled only in IDLE
- `busy` output 1: high from cycle after accepted `start` until `done`
- `done` output 1: one-cycle pulse, last write-back committed
- `rd_en` output 1: read-address pair valid this cycle
- `rd_addr_a`, `rd_addr_b` output N_LOG2: butterfly input addresses
- `tw_addr` output N_LOG2-1: twiddle ROM index, aligned with `rd_en`
- `wr_en` output 1: write `sum` to `wr_addr_a` and `diff` to `wr_addr_b`
- `wr_addr_a`, `wr_addr_b` output N_LOG2: write-back addresses
- `stage` output $clog2(N_LOG2): current stage, for debug/status

## Operation
- FSM states:
  - IDLE: on `start` go to RUN; s=0, k=0.
  - RUN: `rd_en`=1 every cycle; k increments. At k=N/2-1 go to FLUSH.
  - FLUSH: lasts READ_LAT cycles with `rd_en`=0 while the pipeline drains. Then either s++, k=0 and return to RUN, or, if s=N_LOG2-1, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Address math, with half = 1<<s, p = k & (half-1), j = k>>s:
  - `rd_addr_a` = (j<<(s+1)) | p
  - `rd_addr_b` = `rd_addr_a` + half
  - `tw_addr` = p<<(N_LOG2-1-s), truncated to N_LOG2-1 bits
- Write path: `wr_en`, `wr_addr_a` and `wr_addr_b` are `rd_en`, `rd_addr_a` and `rd_addr_b` delayed by exactly READ_LAT cycles through a shift register. No other source drives them.
- FLUSH exists so every stage-s write lands before any stage-s+1 read. No bypass or forwarding is required.
- `start` while not IDLE is ignored. `start` held high re-triggers only from IDLE, i.e. on the cycle after DONE.
- `rst` at any point: next edge forces IDLE, s=k=0, delay line cleared, all outputs 0. An in-flight transform is abandoned and no further writes are issued.

## Timing
- Reset values: every output 0.
- Start handshake: `start` accepted at edge E. `busy`=1 and the first `rd_en`=1 (addresses 0,1, tw 0) both appear after E. First `wr_en` appears READ_LAT cycles later.
- Busy duration: N_LOG2·(N/2 + READ_LAT) cycles of `busy`, followed by a 1-cycle `done` during which `busy`=1. `busy` falls together with the return to IDLE.
- Throughput: one butterfly per cycle inside RUN.
- Outputs: all registered. No combinational path from `start` to any output.

## Configuration
- `FFT_SEQ_STALL_EN`:
  - Defined: adds input `stall` (1 bit). While `stall`=1:
    - FSM, counters and delay line hold.
    - `rd_en` and `wr_en` are forced to 0.
    - Addresses hold.
    - When `stall` drops, operation resumes with no lost or duplicated butterfly.
    - `stall` in IDLE has no effect. `rst` overrides `stall`.
  - Undefined: port absent; behaviour as above with stall tied 0.

## Structure
- Shared package `fft_pkg`:
  - state enum `fft_seq_state_t` {IDLE, RUN, FLUSH, DONE}
  - default `N_LOG2`/`READ_LAT` localparams
  - shared twiddle-width constant, so the twiddle ROM and this block agree.
- One sub-module, `fft_addr_gen`: combinational s, k → `rd_addr_a`, `rd_addr_b`, `tw_addr`. It is reusable by the bench's reference model.

## Test plan
- N_LOG2=3, READ_LAT=1, single `start`:
  - `busy` is high for exactly 15 cycles, then `done` pulses once.
  - Exactly 12 `wr_en` cycles.
- Same config, address checks:
  - stage0 k=0 → a=0, b=1, tw=0
  - stage1 k=1 → a=1, b=3, tw=2
  - stage1 k=2 → a=4, b=6, tw=0
  - stage2 k=3 → a=3, b=7, tw=3
- READ_LAT=3, N_LOG2=4: each `wr_addr` equals `rd_addr` from 3 cycles earlier. No stage-s+1 read precedes the last stage-s write.
- `start` pulsed mid-transform: ignored, and total cycle count is unchanged.
- `rst` asserted in stage 1: next cycle all outputs are 0. A fresh `start` then runs a full transform from stage 0.
- With `FFT_SEQ_STALL_EN`: `stall` high for 5 cycles mid-RUN. Completion is delayed by exactly 5 cycles and the write-address sequence is identical to the unstalled run.
